// File: rtl/pkt_sink_pkg.sv
// Shared types and widths for the packet ejection sink.
`ifndef TYPE_W
`define TYPE_W 4
`endif
`ifndef ID_W
`define ID_W 4
`endif
`ifndef FLIT_W
`define FLIT_W 32
`endif

package pkt_sink_pkg;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [`TYPE_W-1:0] pkt_type;
    logic [`ID_W-1:0]   src;
    logic [`FLIT_W-1:0] data;
  } pkt_entry_t;
endpackage

// File: rtl/pkt_sink_fifo.sv
// Circular-buffer queue with show-ahead head entry; one per traffic class.
`ifndef TYPE_W
`define TYPE_W 4
`endif
`ifndef ID_W
`define ID_W 4
`endif
`ifndef FLIT_W
`define FLIT_W 32
`endif

module pkt_sink_fifo
  import pkt_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  pkt_entry_t               din,
  input  logic                     pop,
  output pkt_entry_t               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  pkt_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full & ~rst;
  assign do_pop  = pop & ~empty & ~rst;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/pkt_eject_sink.sv
// Local ejection sink: target check, two class queues, strict-priority
// presentation with a starvation guard for the normal class.
`ifndef TYPE_W
`define TYPE_W 4
`endif
`ifndef ID_W
`define ID_W 4
`endif
`ifndef FLIT_W
`define FLIT_W 32
`endif

module pkt_eject_sink
  import pkt_sink_pkg::*;
#(
  parameter logic [`ID_W-1:0] MY_ID      = '0,
  parameter int               DEPTH_HI   = 4,
  parameter int               DEPTH_LO   = 8,
  parameter int               STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_out_vld,
  input  logic               pkt_out_qos,
  input  logic [`TYPE_W-1:0] pkt_out_type,
  input  logic [`ID_W-1:0]   pkt_out_src,
  input  logic [`ID_W-1:0]   pkt_out_tgt,
  input  logic [`FLIT_W-1:0] pkt_out_data,
  output logic               pkt_out_rdy,
  output logic               loc_vld,
  output logic               loc_qos,
  output logic [`TYPE_W-1:0] loc_type,
  output logic [`ID_W-1:0]   loc_src,
  output logic [`FLIT_W-1:0] loc_data,
  input  logic               loc_rdy,
  output logic [CNT_W-1:0]   rx_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               err_misroute
);
  localparam int HI_CW = $clog2(DEPTH_HI) + 1;
  localparam int LO_CW = $clog2(DEPTH_LO) + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  pkt_entry_t       in_entry, hi_head, lo_head, sel_head;
  logic [HI_CW-1:0] hi_count;
  logic [LO_CW-1:0] lo_count;
  logic             hi_empty, lo_empty, hi_full, lo_full;
  logic             accept, is_mine, push_hi, push_lo, drop;
  logic             sel_hi, sel_lo, pop_hi, pop_lo;
  logic [ST_W-1:0]  starve_cnt_reg;
  logic [CNT_W-1:0] rx_cnt_reg, drop_cnt_reg;
  logic             err_misroute_reg;
  logic             unused_full;

  // Ready looks only at registered occupancy: a full queue refuses even when it pops.
  assign pkt_out_rdy = ~rst & (pkt_out_qos ? (hi_count < HI_CW'(DEPTH_HI))
                                           : (lo_count < LO_CW'(DEPTH_LO)));
  assign accept  = pkt_out_vld & pkt_out_rdy;
  assign is_mine = (pkt_out_tgt == MY_ID);
  assign push_hi = accept & is_mine & pkt_out_qos;
  assign push_lo = accept & is_mine & ~pkt_out_qos;
  assign drop    = accept & ~is_mine;
  assign in_entry = '{pkt_type: pkt_out_type, src: pkt_out_src, data: pkt_out_data};
  assign unused_full = hi_full | lo_full;

  pkt_sink_fifo #(.DEPTH(DEPTH_HI)) u_hi_q (
    .clk(clk), .rst(rst), .push(push_hi), .din(in_entry), .pop(pop_hi),
    .dout(hi_head), .empty(hi_empty), .full(hi_full), .count(hi_count)
  );

  pkt_sink_fifo #(.DEPTH(DEPTH_LO)) u_lo_q (
    .clk(clk), .rst(rst), .push(push_lo), .din(in_entry), .pop(pop_lo),
    .dout(lo_head), .empty(lo_empty), .full(lo_full), .count(lo_count)
  );

  always_comb begin
    sel_hi   = ~hi_empty & (lo_empty | (starve_cnt_reg < ST_W'(STARVE_MAX)));
    sel_lo   = ~sel_hi & ~lo_empty;
    sel_head = sel_hi ? hi_head : lo_head;
    loc_vld  = sel_hi | sel_lo;
    loc_qos  = sel_hi;
    loc_type = loc_vld ? sel_head.pkt_type : '0;
    loc_src  = loc_vld ? sel_head.src      : '0;
    loc_data = loc_vld ? sel_head.data     : '0;
    pop_hi   = sel_hi & loc_rdy;
    pop_lo   = sel_lo & loc_rdy;
  end

  // The guard blocks hi once the limit is hit, so the counter never passes STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (pop_hi && !lo_empty) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end else if (pop_lo || lo_empty) begin
      starve_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_reg       <= '0;
      drop_cnt_reg     <= '0;
      err_misroute_reg <= 1'b0;
    end else begin
      if ((push_hi || push_lo) && (rx_cnt_reg != '1)) rx_cnt_reg <= rx_cnt_reg + 1'b1;
      if (drop && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      if (drop) err_misroute_reg <= 1'b1;
    end
  end

  assign rx_cnt       = rx_cnt_reg;
  assign drop_cnt     = drop_cnt_reg;
  assign err_misroute = err_misroute_reg;
endmodule

// File: tb/tb_pkt_eject_sink.sv
// Self-checking bench for pkt_eject_sink: table-driven fill/ready vectors,
// a class-split scoreboard for delivered packets, and hand-built corner sequences.
`ifndef TYPE_W
`define TYPE_W 4
`endif
`ifndef ID_W
`define ID_W 4
`endif
`ifndef FLIT_W
`define FLIT_W 32
`endif

module tb_pkt_eject_sink;
  localparam logic [`ID_W-1:0] MY_ID = 4'd3;

  logic               clk = 1'b0;
  logic               rst;
  logic               pkt_out_vld, pkt_out_qos, pkt_out_rdy;
  logic [`TYPE_W-1:0] pkt_out_type;
  logic [`ID_W-1:0]   pkt_out_src, pkt_out_tgt;
  logic [`FLIT_W-1:0] pkt_out_data;
  logic               loc_vld, loc_qos, loc_rdy;
  logic [`TYPE_W-1:0] loc_type;
  logic [`ID_W-1:0]   loc_src;
  logic [`FLIT_W-1:0] loc_data;
  logic [15:0]        rx_cnt, drop_cnt;
  logic               err_misroute;

  pkt_eject_sink #(.MY_ID(MY_ID), .DEPTH_HI(4), .DEPTH_LO(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pkt_out_vld(pkt_out_vld), .pkt_out_qos(pkt_out_qos), .pkt_out_type(pkt_out_type),
    .pkt_out_src(pkt_out_src), .pkt_out_tgt(pkt_out_tgt), .pkt_out_data(pkt_out_data),
    .pkt_out_rdy(pkt_out_rdy),
    .loc_vld(loc_vld), .loc_qos(loc_qos), .loc_type(loc_type), .loc_src(loc_src),
    .loc_data(loc_data), .loc_rdy(loc_rdy),
    .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .err_misroute(err_misroute)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [`TYPE_W-1:0] ty;
    logic [`ID_W-1:0]   src;
    logic [`FLIT_W-1:0] data;
    int                 acc;
    bit                 lat;
  } exp_t;

  typedef struct {
    bit                 vld;
    bit                 qos;
    logic [`ID_W-1:0]   tgt;
    logic [`FLIT_W-1:0] data;
    bit                 exp_rdy;
    logic [15:0]        exp_rx;
    logic [15:0]        exp_drop;
  } vec_t;

  exp_t exp_hi[$];
  exp_t exp_lo[$];
  bit   order_q[$];
  bit   rec_en = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic push_exp(input bit q, input logic [`FLIT_W-1:0] d, input bit lat);
    exp_t e;
    e.ty   = `TYPE_W'(d >> 4);
    e.src  = `ID_W'(d);
    e.data = d;
    e.acc  = cyc;
    e.lat  = lat;
    if (q) exp_hi.push_back(e);
    else   exp_lo.push_back(e);
  endtask

  task automatic drive_pkt(input bit v, input bit q, input logic [`ID_W-1:0] tgt,
                           input logic [`FLIT_W-1:0] d);
    pkt_out_vld  = v;
    pkt_out_qos  = q;
    pkt_out_tgt  = tgt;
    pkt_out_data = d;
    pkt_out_type = `TYPE_W'(d >> 4);
    pkt_out_src  = `ID_W'(d);
  endtask

  // Entered and left at posedge+1; retries until the sink is ready.
  task automatic send(input bit q, input logic [`ID_W-1:0] tgt,
                      input logic [`FLIT_W-1:0] d, input bit lat);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    drive_pkt(1'b1, q, tgt, d);
    while (!done) begin
      @(negedge clk);
      if (pkt_out_rdy) begin
        done = 1'b1;
        if (tgt == MY_ID) push_exp(q, d, lat);
      end else if (n >= 40) begin
        fail_now("send_wait");
        done = 1'b1;
      end
      n++;
      @(posedge clk); #1;
    end
    pkt_out_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    loc_rdy = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (!loc_vld) done = 1'b1;
      else if (n >= 40) begin
        fail_now("drain_wait");
        done = 1'b1;
      end
      n++;
      @(posedge clk); #1;
    end
    loc_rdy = 1'b0;
  endtask

  // Scoreboard consumer: every local handshake must match the head of its class queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && loc_vld && loc_rdy) begin
      if (rec_en) order_q.push_back(loc_qos);
      if ((loc_qos && exp_hi.size() == 0) || (!loc_qos && exp_lo.size() == 0)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: qos=%0b data=0x%0h, expected no packet", loc_qos, loc_data);
      end else begin
        e = loc_qos ? exp_hi.pop_front() : exp_lo.pop_front();
        chk("pop_payload", {24'h0, loc_type, loc_src, loc_data}, {24'h0, e.ty, e.src, e.data});
        if (e.lat) chk("pop_latency", 64'(cyc), 64'(e.acc + 1));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit exp_order[8];
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 4'd3, 32'hB0 + 32'(i), 1'b1, 16'(4 + i), 16'd1};
    tbl[8]  = '{1'b1, 1'b0, 4'd3, 32'hBF, 1'b0, 16'd11, 16'd1};
    tbl[9]  = '{1'b0, 1'b0, 4'd3, 32'h00, 1'b0, 16'd11, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 4'd5, 32'hC5, 1'b1, 16'd11, 16'd2};
    tbl[11] = '{1'b1, 1'b1, 4'd3, 32'hC0, 1'b1, 16'd12, 16'd2};
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    loc_rdy = 1'b0;
    drive_pkt(1'b0, 1'b0, 4'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rdy_during_rst", 64'(pkt_out_rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 64'(pkt_out_rdy), 64'd1);
    chk("rst_loc_vld", 64'(loc_vld), 64'd0);
    chk("rst_rx", 64'(rx_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_err", 64'(err_misroute), 64'd0);
    @(posedge clk); #1;

    // Three in-order normal packets, each visible the cycle after acceptance.
    loc_rdy = 1'b1;
    send(1'b0, 4'd3, 32'hA1, 1'b1);
    send(1'b0, 4'd3, 32'hA2, 1'b1);
    send(1'b0, 4'd3, 32'hA3, 1'b1);
    drain();
    chk("rx_after_three", 64'(rx_cnt), 64'd3);

    // Misrouted packet is counted and flagged, never presented.
    send(1'b0, 4'd5, 32'h55, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("misroute_no_vld", 64'(loc_vld), 64'd0);
      chk("idle_data_zero", 64'(loc_data), 64'd0);
      @(posedge clk); #1;
    end
    chk("misroute_drop", 64'(drop_cnt), 64'd1);
    chk("misroute_err", 64'(err_misroute), 64'd1);
    chk("misroute_rx", 64'(rx_cnt), 64'd3);

    // Fill the normal queue with no consumer, then probe ready per class.
    for (int i = 0; i < 12; i++) begin
      drive_pkt(tbl[i].vld, tbl[i].qos, tbl[i].tgt, tbl[i].data);
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i), 64'(pkt_out_rdy), 64'(tbl[i].exp_rdy));
      if (tbl[i].vld && tbl[i].exp_rdy && tbl[i].tgt == MY_ID) push_exp(tbl[i].qos, tbl[i].data, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rx", i), 64'(rx_cnt), 64'(tbl[i].exp_rx));
      chk($sformatf("tbl%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].exp_drop));
    end
    pkt_out_vld = 1'b0;
    drain();

    // Starvation guard: 4 hi + 2 lo preloaded, 2 more hi arrive while popping.
    for (int i = 0; i < 4; i++) send(1'b1, 4'd3, 32'hD1 + 32'(i), 1'b0);
    send(1'b0, 4'd3, 32'hE1, 1'b0);
    send(1'b0, 4'd3, 32'hE2, 1'b0);
    order_q.delete();
    rec_en  = 1'b1;
    loc_rdy = 1'b1;
    send(1'b1, 4'd3, 32'hD5, 1'b0);
    send(1'b1, 4'd3, 32'hD6, 1'b0);
    for (int n = 0; n < 40 && order_q.size() < 8; n++) begin
      @(posedge clk); #1;
    end
    rec_en  = 1'b0;
    loc_rdy = 1'b0;
    chk("order_len", 64'(order_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < order_q.size()) chk($sformatf("order%0d_qos", i), 64'(order_q[i]), 64'(exp_order[i]));
    drain();

    // Full hi queue refuses even while popping; accepts the next cycle.
    for (int i = 0; i < 4; i++) send(1'b1, 4'd3, 32'hF1 + 32'(i), 1'b0);
    drive_pkt(1'b1, 1'b1, 4'd3, 32'hF5);
    loc_rdy = 1'b1;
    @(negedge clk);
    chk("full_pop_rdy", 64'(pkt_out_rdy), 64'd0);
    chk("full_pop_vld", 64'(loc_vld), 64'd1);
    @(posedge clk); #1;
    loc_rdy = 1'b0;
    @(negedge clk);
    chk("after_pop_rdy", 64'(pkt_out_rdy), 64'd1);
    push_exp(1'b1, 32'hF5, 1'b0);
    @(posedge clk); #1;
    pkt_out_vld = 1'b0;
    @(negedge clk);
    chk("refilled_rdy", 64'(pkt_out_rdy), 64'd0);
    @(posedge clk); #1;
    drain();

    // Reset with traffic queued, then a normal delivery afterwards.
    for (int i = 0; i < 5; i++) send(1'b0, 4'd3, 32'h71 + 32'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", 64'(pkt_out_rdy), 64'd0);
    @(posedge clk); #1;
    exp_lo.delete();
    exp_hi.delete();
    chk("midrst_vld", 64'(loc_vld), 64'd0);
    chk("midrst_rx", 64'(rx_cnt), 64'd0);
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
    chk("midrst_err", 64'(err_misroute), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rdy", 64'(pkt_out_rdy), 64'd1);
    @(posedge clk); #1;
    loc_rdy = 1'b1;
    send(1'b0, 4'd3, 32'h99, 1'b1);
    drain();
    chk("postrst_rx", 64'(rx_cnt), 64'd1);

    chk("sb_hi_left", 64'(exp_hi.size()), 64'd0);
    chk("sb_lo_left", 64'(exp_lo.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
